axi_mem_pattern_master: RTL and testbench



---
 rtl/axi_mem_pattern_master.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_axi_mem_pattern_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_pattern_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_mem_pattern_master
// Brief    : AXI4 master that writes an address-derived pattern with INCR
//            bursts, reads it back and counts mismatching beats.
// Revision : 1.0 - initial release
// ============================================================================

package axi_mem_pattern_master_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_t;
endpackage

module axi_mem_pattern_master #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned BurstLen  = 4,
    parameter type axi_req_t = axi_mem_pattern_master_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_mem_pattern_master_pkg::axi_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [15:0]          num_bursts_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [15:0]          err_cnt_o,
    output axi_req_t             axi_req_o,
    input  axi_rsp_t             axi_rsp_i
);

    localparam int unsigned c_strb_width  = DataWidth / 8;
    localparam int unsigned c_size        = $clog2(c_strb_width);
    localparam int unsigned c_offset_bits = $clog2(BurstLen * c_strb_width);
    localparam int unsigned c_beat_width  = $clog2(BurstLen) + 1;

    localparam logic [AddrWidth-1:0]    c_burst_bytes = AddrWidth'(BurstLen * c_strb_width);
    localparam logic [AddrWidth-1:0]    c_base_mask   = ~((AddrWidth'(1) << c_offset_bits) - AddrWidth'(1));
    localparam logic [c_beat_width-1:0] c_last_beat   = c_beat_width'(BurstLen - 1);
    localparam logic [1:0]              c_resp_okay   = 2'b00;
    localparam logic [1:0]              c_burst_incr  = 2'b01;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_aw   = 3'd1;
    localparam logic [2:0] c_st_w    = 3'd2;
    localparam logic [2:0] c_st_b    = 3'd3;
    localparam logic [2:0] c_st_ar   = 3'd4;
    localparam logic [2:0] c_st_r    = 3'd5;
    localparam logic [2:0] c_st_done = 3'd6;

    logic [2:0]              r_state,      w_state_nxt;
    logic [c_beat_width-1:0] r_beat,       w_beat_nxt;
    logic [15:0]             r_burst,      w_burst_nxt;
    logic [AddrWidth-1:0]    r_burst_addr, w_burst_addr_nxt;
    logic [AddrWidth-1:0]    r_base,       w_base_nxt;
    logic [15:0]             r_num_bursts, w_num_bursts_nxt;
    logic [15:0]             r_err_cnt,    w_err_cnt_nxt;
    axi_req_t                r_req,        w_req_nxt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    logic                 w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [AddrWidth-1:0] w_beat_addr;
    logic                 w_b_bad, w_r_bad;
    logic [16:0]          w_burst_inc;
    logic                 w_more;
    logic [15:0]          w_err_inc;
    logic                 w_unused_rsp;

    // Handshakes are seen against the registered valids/readies we drive.
    assign w_aw_hs = r_req.aw_valid & axi_rsp_i.aw_ready;
    assign w_w_hs  = r_req.w_valid  & axi_rsp_i.w_ready;
    assign w_b_hs  = r_req.b_ready  & axi_rsp_i.b_valid;
    assign w_ar_hs = r_req.ar_valid & axi_rsp_i.ar_ready;
    assign w_r_hs  = r_req.r_ready  & axi_rsp_i.r_valid;

    assign w_beat_addr = r_burst_addr + (AddrWidth'(r_beat) << c_size);
    assign w_b_bad     = (axi_rsp_i.b.resp != c_resp_okay) || (axi_rsp_i.b.id != IdWidth'(0));
    assign w_r_bad     = (axi_rsp_i.r.data != DataWidth'(w_beat_addr))
                      || (axi_rsp_i.r.resp != c_resp_okay)
                      || (axi_rsp_i.r.last != (r_beat == c_last_beat));
    assign w_burst_inc = {1'b0, r_burst} + 17'd1;
    assign w_more      = w_burst_inc < {1'b0, r_num_bursts};
    assign w_err_inc   = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

    assign w_unused_rsp = ^{axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.user};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_st_idle;
            r_beat       <= '0;
            r_burst      <= '0;
            r_burst_addr <= '0;
            r_base       <= '0;
            r_num_bursts <= '0;
            r_err_cnt    <= '0;
            r_req        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_burst      <= w_burst_nxt;
            r_burst_addr <= w_burst_addr_nxt;
            r_base       <= w_base_nxt;
            r_num_bursts <= w_num_bursts_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_req        <= w_req_nxt;
            r_busy       <= (w_state_nxt != c_st_idle);
            r_done       <= (r_state == c_st_done);
            r_error      <= (w_err_cnt_nxt != 16'd0);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_nxt       = r_beat;
        w_burst_nxt      = r_burst;
        w_burst_addr_nxt = r_burst_addr;
        w_base_nxt       = r_base;
        w_num_bursts_nxt = r_num_bursts;
        w_err_cnt_nxt    = r_err_cnt;
        case (r_state)
            c_st_idle: begin
                if (start_i) begin
                    w_base_nxt       = base_addr_i & c_base_mask;
                    w_burst_addr_nxt = base_addr_i & c_base_mask;
                    w_num_bursts_nxt = num_bursts_i;
                    w_err_cnt_nxt    = '0;
                    w_burst_nxt      = '0;
                    w_beat_nxt       = '0;
                    w_state_nxt      = (num_bursts_i != 16'd0) ? c_st_aw : c_st_done;
                end
            end
            c_st_aw: begin
                if (w_aw_hs) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = c_st_w;
                end
            end
            c_st_w: begin
                if (w_w_hs) begin
                    if (r_beat == c_last_beat) begin
                        w_state_nxt = c_st_b;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            c_st_b: begin
                if (w_b_hs) begin
                    if (w_b_bad) begin
                        w_err_cnt_nxt = w_err_inc;
                    end
                    if (w_more) begin
                        w_burst_nxt      = w_burst_inc[15:0];
                        w_burst_addr_nxt = r_burst_addr + c_burst_bytes;
                        w_state_nxt      = c_st_aw;
                    end else begin
                        w_burst_nxt      = '0;
                        w_burst_addr_nxt = r_base;
                        w_state_nxt      = c_st_ar;
                    end
                end
            end
            c_st_ar: begin
                if (w_ar_hs) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = c_st_r;
                end
            end
            c_st_r: begin
                if (w_r_hs) begin
                    if (w_r_bad) begin
                        w_err_cnt_nxt = w_err_inc;
                    end
                    // The slave's last flag, not our beat count, closes the burst.
                    if (axi_rsp_i.r.last) begin
                        if (w_more) begin
                            w_burst_nxt      = w_burst_inc[15:0];
                            w_burst_addr_nxt = r_burst_addr + c_burst_bytes;
                            w_state_nxt      = c_st_ar;
                        end else begin
                            w_state_nxt = c_st_done;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Request fields are derived from the next state so they leave flops.
    always_comb begin
        w_req_nxt = '0;
        if ((w_state_nxt != c_st_idle) && (w_state_nxt != c_st_done)) begin
            w_req_nxt.aw.id    = IdWidth'(0);
            w_req_nxt.aw.addr  = w_burst_addr_nxt;
            w_req_nxt.aw.len   = 8'(BurstLen - 1);
            w_req_nxt.aw.size  = 3'(c_size);
            w_req_nxt.aw.burst = c_burst_incr;
            w_req_nxt.aw.user  = UserWidth'(0);
            w_req_nxt.aw_valid = (w_state_nxt == c_st_aw);

            w_req_nxt.w.data   = DataWidth'(w_burst_addr_nxt + (AddrWidth'(w_beat_nxt) << c_size));
            w_req_nxt.w.strb   = '1;
            w_req_nxt.w.last   = (w_state_nxt == c_st_w) && (w_beat_nxt == c_last_beat);
            w_req_nxt.w.user   = UserWidth'(0);
            w_req_nxt.w_valid  = (w_state_nxt == c_st_w);

            w_req_nxt.b_ready  = (w_state_nxt == c_st_b);

            w_req_nxt.ar.id    = IdWidth'(0);
            w_req_nxt.ar.addr  = w_burst_addr_nxt;
            w_req_nxt.ar.len   = 8'(BurstLen - 1);
            w_req_nxt.ar.size  = 3'(c_size);
            w_req_nxt.ar.burst = c_burst_incr;
            w_req_nxt.ar.user  = UserWidth'(0);
            w_req_nxt.ar_valid = (w_state_nxt == c_st_ar);

            w_req_nxt.r_ready  = (w_state_nxt == c_st_r);
        end
    end

    assign axi_req_o = r_req;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign error_o   = r_error;
    assign err_cnt_o = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_pattern_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_pattern_master
// Brief    : Directed bench with a behavioural AXI4 memory slave.
// Revision : 1.0 - initial release
// ============================================================================

module tb_axi_mem_pattern_master;
    import axi_mem_pattern_master_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [15:0] nb;
    logic        busy, done, error;
    logic [15:0] err_cnt;
    axi_req_t    req;
    axi_rsp_t    rsp;

    axi_mem_pattern_master dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .base_addr_i  (base),
        .num_bursts_i (nb),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .err_cnt_o    (err_cnt),
        .axi_req_o    (req),
        .axi_rsp_i    (rsp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural memory slave
    logic [63:0] mem [logic [31:0]];
    logic [2:0]  aw_stall = 3'd0, w_stall = 3'd0, ar_stall = 3'd0;
    bit          stall_en = 1'b0, ar_hold = 1'b0, bd_we = 1'b0;
    logic [31:0] bd_addr = '0;
    logic [31:0] wr_addr = '0, rd_addr = '0;
    logic [7:0]  wr_beat = '0, rd_beat = '0, rd_len = '0;
    logic        b_pend = 1'b0, rd_act = 1'b0;
    logic [63:0] rd_data = '0;
    int          b_count = 0;
    int          slverr_at = -1;

    function automatic logic [63:0] rdmem(input logic [31:0] a);
        logic [31:0] key;
        key = a & ~32'd7;
        return mem.exists(key) ? mem[key] : 64'd0;
    endfunction

    always_comb begin
        rsp          = '0;
        rsp.aw_ready = (aw_stall == 3'd0);
        rsp.w_ready  = (w_stall == 3'd0);
        rsp.ar_ready = (ar_stall == 3'd0) && !ar_hold;
        rsp.b_valid  = b_pend;
        rsp.b.resp   = (b_count == slverr_at) ? 2'b10 : 2'b00;
        rsp.r_valid  = rd_act;
        rsp.r.data   = rd_data;
        rsp.r.last   = (rd_beat == rd_len);
    end

    always @(posedge clk) begin
        logic [63:0] tmp;
        if (rst) begin
            b_pend <= 1'b0; rd_act <= 1'b0; wr_beat <= '0; rd_beat <= '0;
            aw_stall <= 3'd0; w_stall <= 3'd0; ar_stall <= 3'd0;
        end else begin
            if (bd_we) begin
                tmp = rdmem(bd_addr);
                tmp[7:0] = 8'hFF;
                mem[bd_addr & ~32'd7] = tmp;
            end
            if (req.aw_valid && rsp.aw_ready) begin
                wr_addr  <= req.aw.addr;
                wr_beat  <= '0;
                aw_stall <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
            end else if (aw_stall != 3'd0) aw_stall <= aw_stall - 3'd1;
            if (req.w_valid && rsp.w_ready) begin
                mem[(wr_addr + 32'({wr_beat, 3'b000})) & ~32'd7] = req.w.data;
                wr_beat <= wr_beat + 8'd1;
                if (req.w.last) b_pend <= 1'b1;
                w_stall <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
            end else if (w_stall != 3'd0) w_stall <= w_stall - 3'd1;
            if (b_pend && req.b_ready) begin
                b_pend  <= 1'b0;
                b_count <= b_count + 1;
            end
            if (req.ar_valid && rsp.ar_ready) begin
                rd_act   <= 1'b1;
                rd_addr  <= req.ar.addr;
                rd_beat  <= '0;
                rd_len   <= req.ar.len;
                rd_data  <= rdmem(req.ar.addr);
                ar_stall <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
            end else if (ar_stall != 3'd0) ar_stall <= ar_stall - 3'd1;
            if (rd_act && req.r_ready) begin
                if (rd_beat == rd_len) rd_act <= 1'b0;
                else begin
                    rd_beat <= rd_beat + 8'd1;
                    rd_data <= rdmem(rd_addr + 32'({rd_beat + 8'd1, 3'b000}));
                end
            end
        end
    end

    // Monitors: beat log, handshake/done counters, valid/payload stability
    logic [63:0]  wq[$];
    int           done_cnt = 0, hs_cnt = 0, r_cnt = 0, viol = 0;
    bit           p_aw_pend = 0, p_w_pend = 0, p_ar_pend = 0;
    axi_aw_chan_t p_aw;
    axi_w_chan_t  p_w;
    axi_ar_chan_t p_ar;

    always @(posedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (req.w_valid && rsp.w_ready) wq.push_back(req.w.data);
        if (req.r_ready && rsp.r_valid) r_cnt = r_cnt + 1;
        if ((req.aw_valid && rsp.aw_ready) || (req.w_valid && rsp.w_ready) ||
            (req.ar_valid && rsp.ar_ready)) hs_cnt = hs_cnt + 1;
        if (rst) begin
            p_aw_pend = 0; p_w_pend = 0; p_ar_pend = 0;
        end else begin
            if (p_aw_pend && (!req.aw_valid || req.aw != p_aw)) viol = viol + 1;
            if (p_w_pend  && (!req.w_valid  || req.w  != p_w))  viol = viol + 1;
            if (p_ar_pend && (!req.ar_valid || req.ar != p_ar)) viol = viol + 1;
            p_aw_pend = req.aw_valid && !rsp.aw_ready; p_aw = req.aw;
            p_w_pend  = req.w_valid  && !rsp.w_ready;  p_w  = req.w;
            p_ar_pend = req.ar_valid && !rsp.ar_ready; p_ar = req.ar;
        end
    end

    task automatic start_run(input logic [31:0] b, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; base = b; nb = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, done, 1);
        @(negedge clk);
        check({tag, "_done_single"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (errors=%0d of %0d checks)", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, k, w0, r0, d0, h0, v0, bad;
        rst = 1'b1; start = 1'b0; base = '0; nb = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_req_all_zero", (req == '0), 1);
        rst = 1'b0;

        // Basic write/read of two bursts from 0x1000
        w0 = wq.size(); r0 = r_cnt; d0 = done_cnt;
        start_run(32'h1000, 16'd2);
        check("t1_aw_valid_after_start", req.aw_valid, 1);
        check("t1_busy", busy, 1);
        n = 1;
        while (!(req.b_ready && rsp.b_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t1_write_burst_cycles", n, 6);
        wait_done("t1");
        check("t1_w_beats", wq.size() - w0, 8);
        for (int i = 0; i < 8; i++) begin
            check("t1_w_data", wq[w0 + i], 64'h1000 + 64'(8 * i));
            check("t1_mem", rdmem(32'h1000 + 32'(8 * i)), 64'h1000 + 64'(8 * i));
        end
        check("t1_r_beats", r_cnt - r0, 8);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_error", error, 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Corrupt byte 0x1010 between write and read phases
        ar_hold = 1'b1;
        start_run(32'h1000, 16'd2);
        k = 0;
        while (!req.ar_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t2_read_phase_reached", req.ar_valid, 1);
        bd_addr = 32'h1010; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0; ar_hold = 1'b0;
        wait_done("t2");
        check("t2_err_cnt", err_cnt, 1);
        check("t2_error", error, 1);

        // SLVERR on the second write response
        slverr_at = b_count + 1;
        r0 = r_cnt;
        start_run(32'h1000, 16'd2);
        wait_done("t3");
        slverr_at = -1;
        check("t3_err_cnt", err_cnt, 1);
        check("t3_error", error, 1);
        check("t3_r_beats", r_cnt - r0, 8);

        // Random ready stalls on aw/w/ar
        stall_en = 1'b1;
        w0 = wq.size(); r0 = r_cnt; v0 = viol;
        start_run(32'h2000, 16'd3);
        wait_done("t4");
        stall_en = 1'b0;
        check("t4_w_beats", wq.size() - w0, 12);
        bad = 0;
        for (int i = 0; i < 12; i++)
            if (wq[w0 + i] !== 64'h2000 + 64'(8 * i)) bad++;
        check("t4_w_order", bad, 0);
        check("t4_r_beats", r_cnt - r0, 12);
        check("t4_stability", viol - v0, 0);
        check("t4_err_cnt", err_cnt, 0);

        // Reset while W beat 2 of burst 0 is presented
        start_run(32'h3000, 16'd2);
        k = 0;
        while (!(req.w_valid && req.w.data == 64'h3010) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_beat2_reached", req.w_valid && (req.w.data == 64'h3010), 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t5_valids_dropped",
              {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, 0);
        check("t5_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        start_run(32'h3000, 16'd2);
        wait_done("t5_restart");
        check("t5_err_cnt", err_cnt, 0);
        check("t5_error", error, 0);

        // Zero bursts: no traffic, done at start+2
        h0 = hs_cnt;
        start_run(32'h1234, 16'd0);
        check("t6_busy_c1", busy, 1);
        check("t6_done_c1", done, 0);
        @(negedge clk);
        check("t6_done_c2", done, 1);
        @(negedge clk);
        check("t6_done_c3", done, 0);
        check("t6_no_handshakes", hs_cnt - h0, 0);

        // Unaligned base is rounded down to the burst boundary
        w0 = wq.size();
        start_run(32'h1234, 16'd1);
        check("t7_aw_addr", req.aw.addr, 32'h1220);
        wait_done("t7");
        check("t7_first_w_data", wq[w0], 64'h1220);
        check("t7_err_cnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
